// File: rtl/reg_mux_pipe.sv
// -----------------------------------------------------------------------------
// reg_mux_pipe
//   General-purpose registered datapath primitive. Four independent registered
//   functions share one clock and one synchronous active-high reset:
//     * WIDTH-bit, DEPTH-stage delay line with shift enable and fill flag
//     * NCH-way registered channel multiplexer (out-of-range select -> 0)
//     * mode-selectable registered bitwise logic unit (x and its complement y)
//     * registered rise/fall edge detector on d[0]
//
// Ports
//   clk      in   1          rising-edge clock
//   reset    in   1          synchronous, active-high; priority over all inputs
//   en       in   1          delay-line shift enable
//   d        in   WIDTH      delay-line input
//   q        out  WIDTH      delay-line output (last stage)
//   q_valid  out  1          q carries a post-reset sample (sticky until reset)
//   ch_in    in   NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   s        in   SEL_W      channel select
//   sel_o    out  WIDTH      registered selected channel
//   a, b     in   WIDTH      logic-unit operands
//   mode     in   2          0=AND 1=OR 2=XOR 3=NAND
//   x        out  WIDTH      registered a op b
//   y        out  WIDTH      registered ~(a op b)
//   rise     out  1          one-cycle pulse on a 0->1 change of d[0]
//   fall     out  1          one-cycle pulse on a 1->0 change of d[0]
//
// Valid semantics: q_valid qualifies q. There is no back-pressure; a new q
// value is presented on every edge where en=1 while q_valid is high, and q
// holds its value on edges where en=0.
// -----------------------------------------------------------------------------
module reg_mux_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  input  logic [NCH*WIDTH-1:0]   ch_in,
  input  logic [SEL_W-1:0]       s,
  output logic [WIDTH-1:0]       sel_o,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic [1:0]             mode,
  output logic [WIDTH-1:0]       x,
  output logic [WIDTH-1:0]       y,
  output logic                   rise,
  output logic                   fall
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Delay line and fill counter
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] stage [DEPTH];
  logic [CNT_W-1:0] fill_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      fill_cnt <= '0;
      q_valid  <= 1'b0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      if (fill_cnt != CNT_W'(DEPTH)) fill_cnt <= fill_cnt + CNT_W'(1);
      // The shift that brings the count to DEPTH is the one that moves the
      // first post-reset sample into the last stage, so q_valid rises with it.
      if (fill_cnt == CNT_W'(DEPTH - 1)) q_valid <= 1'b1;
    end
  end

  assign q = stage[DEPTH-1];

  // ---------------------------------------------------------------------------
  // Channel multiplexer: selects outside 0..NCH-1 give a defined zero
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mux_next;

  always_comb begin
    mux_next = '0;
    for (int k = 0; k < NCH; k++) begin
      if (s == SEL_W'(k)) mux_next = ch_in[k*WIDTH +: WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Logic unit
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] lu_next;

  always_comb begin
    lu_next = '0;
    case (mode)
      2'd0:    lu_next = a & b;
      2'd1:    lu_next = a | b;
      2'd2:    lu_next = a ^ b;
      default: lu_next = ~(a & b);
    endcase
  end

  // ---------------------------------------------------------------------------
  // Mux, logic unit and edge detector registers (all independent of en)
  // ---------------------------------------------------------------------------
  logic d0_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_o   <= '0;
      x       <= '0;
      y       <= '1;
      d0_prev <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sel_o   <= mux_next;
      x       <= lu_next;
      y       <= ~lu_next;
      d0_prev <= d[0];
      rise    <= d[0] & ~d0_prev;
      fall    <= ~d[0] & d0_prev;
    end
  end

endmodule

// File: doc/reg_mux_pipe.md
# reg_mux_pipe

Parametrised successor to the single-bit register/mux/gate block. It combines four registered functions that share one clock and one synchronous reset:

- a WIDTH-bit, DEPTH-stage delay line with clock enable and a fill-valid flag;
- an NCH-way registered channel multiplexer;
- a mode-selectable registered bitwise logic unit;
- a registered rise/fall edge detector on bit 0 of the delay-line input.

It serves as the general-purpose registered datapath primitive for the board designs.

## Interface
Parameters:
- WIDTH, 8, data width of d, q, channel inputs, a, b, x, y; must be ≥1
- DEPTH, 4, delay-line stages; must be ≥1
- NCH, 4, number of mux channels; must be ≥2
- SEL_W, 2, select width; requires 2^SEL_W ≥ NCH

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk edge
- en  in  1  delay-line shift enable
- d  in  WIDTH  delay-line input
- q  out  WIDTH  delay-line output (stage DEPTH)
- q_valid  out  1  high once DEPTH enabled shifts have occurred since reset
- ch_in  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- s  in  SEL_W  channel select
- sel_o  out  WIDTH  registered selected channel
- a, b  in  WIDTH  logic-unit operands
- mode  in  2  0=AND, 1=OR, 2=XOR, 3=NAND
- x  out  WIDTH  registered a op b
- y  out  WIDTH  registered bitwise complement of x's next value
- rise, fall  out  1  one-cycle edge pulses on d[0]

## Operation
- **Reset (reset=1 at a clk edge)**:
  - all delay stages, q, sel_o and x clear to 0;
  - y is set to all-ones;
  - q_valid, rise and fall clear to 0;
  - the fill counter and the edge-history register d0_prev clear to 0.
  - Reset has priority over en and all other inputs.
- **Delay line**:
  - With en=1, stage1<=d and stage(i)<=stage(i-1); q=stage DEPTH.
  - With en=0, all stages hold.
  - The fill counter (width clog2(DEPTH+1)) increments on each enabled shift and saturates at DEPTH.
  - q_valid = (count==DEPTH), registered. Once high it stays high until reset.
- **Mux**:
  - sel_o <= channel s when s<NCH.
  - sel_o <= 0 when s≥NCH (out-of-range select is a defined zero, not X).
  - Updates every cycle, independent of en.
- **Logic unit**:
  - x <= a op b per mode.
  - y <= ~(a op b).
  - Updates every cycle, independent of en.
- **Edge detect** (independent of en):
  - Every cycle: d0_prev <= d[0].
  - rise <= d[0] & ~d0_prev.
  - fall <= ~d[0] & d0_prev.
- No state machine beyond the fill counter.

## Timing
- **q latency**: d sampled at an enabled edge appears on q after exactly DEPTH enabled edges. Disabled cycles stretch the latency without losing data.
- **q_valid**: rises on the same edge that delivers the first post-reset sample to q, i.e. at the DEPTH-th enabled edge after reset release.
- **sel_o, x, y**: 1-cycle latency from the inputs sampled at the edge.
- **rise/fall**:
  - Asserted for exactly one cycle, starting at the edge where d[0] is first sampled at its new value.
  - d[0]=1 at the first edge after reset produces rise=1 (history is 0).
  - A 1-cycle glitch on d[0] yields rise then fall on consecutive cycles.
- **Reset mid-operation**: the pipeline contents are discarded. q_valid drops at that edge and requires DEPTH new enabled shifts.
- **DEPTH=1**: q is a single enabled register. q_valid rises at the first enabled edge.

## Test plan
1. **Reset and fill**: reset=1 for 10 clks with d=8'hFF, en=1.
   - During reset: q=0, q_valid=0, y=8'hFF.
   - After release, drive d=1,2,3,4,5: q=1 and q_valid=1 on the 4th edge after release, then q=2,3 follow.
2. **Enable stall**: mid-stream, hold en=0 for 3 cycles with d changing.
   - q and q_valid frozen.
   - Resuming yields the exact pre-stall sequence with no dropped or duplicated values.
3. **Mux sweep**: ch_in={8'h44,8'h33,8'h22,8'h11}, s=0..3.
   - sel_o=11,22,33,44, each one cycle later.
   - With NCH=3, SEL_W=2 and s=3: sel_o=0.
4. **Logic modes**: a=8'hF0, b=8'h3C.
   - mode=0→x=30,y=CF.
   - mode=1→x=FC,y=03.
   - mode=2→x=CC,y=33.
   - mode=3→x=CF,y=30.
5. **Edges**: d[0] sequence 0,1,1,0,1,0.
   - rise pulses after edges 2 and 5.
   - fall pulses after edges 4 and 6.
   - Each pulse is exactly 1 cycle wide.
6. **Reset mid-operation**: pulse reset for 1 cycle while q_valid=1.
   - Next cycle: q=0, q_valid=0, x=0, y=FF.
   - q_valid returns after 4 enabled edges.
